// File: rtl/mpy_pkg.sv
// Shared definitions for the sequential signed multiplier: default operand
// width, FSM state type and a sign-extension helper.
package mpy_pkg;

  localparam int W_DEFAULT = 4;

  typedef enum logic {
    IDLE,
    CALC
  } state_t;

  // Sign-extend the low 'width' bits of x to 64 bits. Callers cast the
  // result down to the width they need.
  function automatic logic [63:0] sign_extend(input logic [63:0] x, input int width);
    logic [63:0] t;
    t = x << (64 - width);
    return 64'($signed(t) >>> (64 - width));
  endfunction

endpackage

// File: rtl/mpy_if.sv
// Operand/result bundle for the multiplier. The harness drives the operands
// and reads back the product.
interface mpy_if
  import mpy_pkg::*;
#(
  parameter int W = W_DEFAULT
) ();

  logic signed [W-1:0]   a;
  logic signed [W-1:0]   b;
  logic signed [2*W-1:0] product;

  modport master (output a, output b, input product);
  modport slave  (input a, input b, output product);

endinterface

// File: rtl/mpy_pp.sv
// Partial-product generator. For iteration cnt it returns the sign-extended
// multiplicand shifted by cnt when that bit of the multiplier is set. The last
// iteration covers the multiplier's sign bit, which carries negative weight,
// so it is flagged for subtraction.
module mpy_pp
  import mpy_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [W-1:0]         a_q,
  input  logic [W-1:0]         b_q,
  input  logic [$clog2(W)-1:0] cnt,
  output logic [2*W-1:0]       pp,
  output logic                 sub
);

  localparam int CW = $clog2(W);
  localparam int PW = 2 * W;

  logic [PW-1:0] a_ext;

  assign a_ext = PW'(sign_extend(64'(a_q), W));
  assign sub   = (cnt == CW'(W - 1));

  // Select the shifted multiplicand or zero depending on the current multiplier bit
  always_comb begin
    pp = '0;
    if (b_q[cnt]) begin
      pp = a_ext << cnt;
    end
  end

endmodule

// File: rtl/mpy.sv
// Sequential signed shift-and-add multiplier. It watches its operands and,
// whenever they differ from the last latched pair, runs one partial product
// per clock. The product register only updates when a computation completes,
// so the output never shows intermediate sums.
module mpy
  import mpy_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic  clk,
  input  logic  rst_n,
  mpy_if.slave  bus
);

  localparam int CW = $clog2(W);
  localparam int PW = 2 * W;

  state_t        state;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [PW-1:0] acc;
  logic [PW-1:0] acc_next;
  logic [PW-1:0] product_q;
  logic [PW-1:0] pp;
  logic [CW-1:0] cnt;
  logic          sub;
  logic          changed;

  mpy_pp #(.W(W)) u_pp (
    .a_q (a_q),
    .b_q (b_q),
    .cnt (cnt),
    .pp  (pp),
    .sub (sub)
  );

  assign changed     = ({bus.a, bus.b} != {a_q, b_q});
  assign acc_next    = sub ? (acc - pp) : (acc + pp);
  assign bus.product = product_q;

  // Control FSM: latch new operands in IDLE, accumulate one bit per cycle in CALC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      cnt       <= '0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (changed) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            acc   <= '0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc_next;
          if (sub) begin
            product_q <= acc_next;
            cnt       <= '0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpy.sv
// Testbench for mpy: directed cases, a mid-computation operand change, reset
// abort, an exhaustive sweep and randomized operand pairs, all compared
// against plain signed multiplication.
module tb_mpy;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [7:0] model_product;

  mpy_if #(.W(4)) bus ();

  mpy #(.W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] ref_mul(input int x, input int y);
    int p;
    p = x * y;
    return p[7:0];
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int av, input int bv);
    bus.a = 4'(av);
    bus.b = 4'(bv);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] expected);
    checks++;
    assert (bus.product === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%02h expected=0x%02h", tag, bus.product, expected);
    end
  endtask

  // Run one pair with the FSM idle: old value held after 4 edges, new after 5
  task automatic runPair(input string tag, input int av, input int bv);
    logic [7:0] old_val;
    old_val = model_product;
    applyStimulus(av, bv);
    step(4);
    checkOutput({tag, "_hold"}, old_val);
    step(1);
    model_product = ref_mul(av, bv);
    checkOutput(tag, model_product);
  endtask

  // Directed and randomized stimulus sequence
  initial begin
    int av;
    int bv;
    checks = 0;
    failures = 0;
    model_product = 8'h00;
    rst_n = 1'b0;
    applyStimulus(0, 0);

    step(2);
    checkOutput("reset_product", 8'h00);
    rst_n = 1'b1;
    step(3);
    checkOutput("zero_hold_a", 8'h00);
    step(6);
    checkOutput("zero_hold_b", 8'h00);

    runPair("3x5", 3, 5);
    runPair("m8xm8", -8, -8);
    runPair("m8x7", -8, 7);
    runPair("7x7", 7, 7);
    runPair("m1x1", -1, 1);

    // Operands change one edge after the first latch
    applyStimulus(2, 3);
    step(1);
    applyStimulus(-3, 4);
    step(3);
    checkOutput("restart_old", 8'hFF);
    step(1);
    checkOutput("restart_first", ref_mul(2, 3));
    step(4);
    checkOutput("restart_first_held", ref_mul(2, 3));
    step(1);
    checkOutput("restart_second", ref_mul(-3, 4));
    model_product = ref_mul(-3, 4);

    // Reset asserted in the middle of a computation
    applyStimulus(5, -2);
    step(2);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_abort", 8'h00);
    step(1);
    checkOutput("reset_held", 8'h00);
    rst_n = 1'b1;
    model_product = 8'h00;
    runPair("after_reset", 5, -2);

    // Same operands again leave the product untouched
    applyStimulus(5, -2);
    step(5);
    checkOutput("same_operands", model_product);

    // Exhaustive sweep, each pair held 8 edges
    for (int i = -8; i < 8; i++) begin
      for (int j = -8; j < 8; j++) begin
        applyStimulus(i, j);
        step(8);
        checkOutput("sweep", ref_mul(i, j));
      end
    end
    model_product = ref_mul(7, 7);

    // Randomized pairs with hold-then-update timing
    for (int k = 0; k < 40; k++) begin
      av = int'($urandom_range(0, 15)) - 8;
      bv = int'($urandom_range(0, 15)) - 8;
      runPair("random", av, bv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
